// File: rtl/flags_status_reg_pkg.sv
// flags_status_reg_pkg: shared state codes and flag bit positions for the status stage and display decoder
package flags_status_reg_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_LOCK = 2'b10
    } state_t;
    localparam int FLAG_OVF   = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_ERR   = 3;
    function automatic logic [3:0] pack_flags(input logic ovf, input logic zero, input logic carry, input logic err);
        logic [3:0] f;
        f = '0;
        f[FLAG_OVF]   = ovf;
        f[FLAG_ZERO]  = zero;
        f[FLAG_CARRY] = carry;
        f[FLAG_ERR]   = err;
        return f;
    endfunction
endpackage

// File: rtl/flags_status_reg_rise_detect.sv
// rise_detect: rising-edge detector; clk, rst (async high), din -> rise; register resets to 1 so a level held through reset is not an edge
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    logic din_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) din_q <= 1'b1;
        else     din_q <= din;
    assign rise = din & ~din_q;
endmodule

// File: rtl/flags_status_reg.sv
// flags_status_reg: captures ALU result/op/flags on Exec edge and offers them via OutValid/OutReady; Err locks until Clear; Overflow captures counted (saturating); all outputs registered
module flags_status_reg
    import flags_status_reg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Exec,
    input  logic             Clear,
    input  logic [WIDTH-1:0] Result,
    input  logic [2:0]       Op,
    input  logic             Overflow,
    input  logic             Zero,
    input  logic             CarryOut,
    input  logic             Err,
    input  logic             OutReady,
    output logic             OutValid,
    output logic [WIDTH-1:0] ResultQ,
    output logic [2:0]       OpQ,
    output logic [3:0]       FlagsQ,
    output logic             ErrSticky,
    output logic             Drop,
    output logic [CNT_W-1:0] OvfCount,
    output logic [1:0]       State
);
    state_t st;
    logic   exec_rise;
    logic   in_idle;
    logic   accept;
    rise_detect u_rise (
        .clk  (clk),
        .rst  (rst),
        .din  (Exec),
        .rise (exec_rise)
    );
    // unused code 11 behaves as IDLE
    assign in_idle = (st != ST_HOLD) && (st != ST_LOCK);
    assign accept  = exec_rise && (in_idle || (st == ST_HOLD && OutReady));
    assign State   = st;
    always_ff @(posedge clk or posedge rst) begin
        if (rst || Clear) begin
            st        <= ST_IDLE;
            OutValid  <= 1'b0;
            ResultQ   <= '0;
            OpQ       <= '0;
            FlagsQ    <= '0;
            ErrSticky <= 1'b0;
            Drop      <= 1'b0;
            OvfCount  <= '0;
        end else begin
            Drop <= 1'b0;
            if (accept) begin
                ResultQ   <= Result;
                OpQ       <= Op;
                FlagsQ    <= pack_flags(Overflow, Zero, CarryOut, Err);
                OutValid  <= 1'b1;
                ErrSticky <= Err;
                st        <= Err ? ST_LOCK : ST_HOLD;
                if (Overflow && OvfCount != {CNT_W{1'b1}}) OvfCount <= OvfCount + CNT_W'(1);
            end else if (st == ST_HOLD) begin
                if (exec_rise) Drop <= 1'b1;
                else if (OutReady) begin
                    OutValid <= 1'b0;
                    st       <= ST_IDLE;
                end
            end else if (st == ST_LOCK) begin
                Drop <= exec_rise;
                if (OutReady) OutValid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_flags_status_reg.sv
// tb_flags_status_reg: directed self-checking bench for flags_status_reg
module tb_flags_status_reg;
    logic       clk = 1'b0;
    logic       rst, Exec, Clear, Overflow, Zero, CarryOut, Err, OutReady;
    logic [3:0] Result;
    logic [2:0] Op;
    logic       OutValid, ErrSticky, Drop;
    logic [3:0] ResultQ, FlagsQ, OvfCount;
    logic [2:0] OpQ;
    logic [1:0] State;
    int n_checks = 0;
    int n_fail   = 0;
    flags_status_reg #(.WIDTH(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .Exec(Exec), .Clear(Clear), .Result(Result), .Op(Op),
        .Overflow(Overflow), .Zero(Zero), .CarryOut(CarryOut), .Err(Err), .OutReady(OutReady),
        .OutValid(OutValid), .ResultQ(ResultQ), .OpQ(OpQ), .FlagsQ(FlagsQ),
        .ErrSticky(ErrSticky), .Drop(Drop), .OvfCount(OvfCount), .State(State)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic all_zero(input string tag);
        check({tag, " OutValid"}, int'(OutValid), 0);
        check({tag, " ResultQ"}, int'(ResultQ), 0);
        check({tag, " OpQ"}, int'(OpQ), 0);
        check({tag, " FlagsQ"}, int'(FlagsQ), 0);
        check({tag, " ErrSticky"}, int'(ErrSticky), 0);
        check({tag, " Drop"}, int'(Drop), 0);
        check({tag, " OvfCount"}, int'(OvfCount), 0);
        check({tag, " State"}, int'(State), 0);
    endtask
    initial begin
        rst = 1; Exec = 1; Clear = 0; Overflow = 0; Zero = 0; CarryOut = 0; Err = 0;
        OutReady = 0; Result = 0; Op = 0;
        tick(); tick();
        all_zero("reset");
        rst = 0;
        tick();
        check("t1 OutValid", int'(OutValid), 0);
        check("t1 State", int'(State), 0);
        check("t1 Drop", int'(Drop), 0);
        Exec = 0;
        tick();
        Result = 4'h0; Zero = 1; Op = 3'd2; Exec = 1;
        tick();
        check("t2 OutValid", int'(OutValid), 1);
        check("t2 ResultQ", int'(ResultQ), 0);
        check("t2 FlagsQ", int'(FlagsQ), 2);
        check("t2 OpQ", int'(OpQ), 2);
        check("t2 State", int'(State), 1);
        Exec = 0; OutReady = 1; Zero = 0;
        tick();
        check("t2 hs OutValid", int'(OutValid), 0);
        check("t2 hs State", int'(State), 0);
        OutReady = 0; Result = 4'h5; Op = 3'd1; Exec = 1;
        tick();
        check("t3 first ResultQ", int'(ResultQ), 5);
        Exec = 0;
        tick();
        Result = 4'h7; Exec = 1;
        tick();
        check("t3 Drop", int'(Drop), 1);
        check("t3 ResultQ kept", int'(ResultQ), 5);
        check("t3 State", int'(State), 1);
        Exec = 0;
        tick();
        check("t3 Drop one cycle", int'(Drop), 0);
        Result = 4'h9; OutReady = 1; Exec = 1;
        tick();
        check("t3 b2b OutValid", int'(OutValid), 1);
        check("t3 b2b ResultQ", int'(ResultQ), 9);
        check("t3 b2b State", int'(State), 1);
        check("t3 b2b Drop", int'(Drop), 0);
        Exec = 0;
        tick();
        check("t3 end State", int'(State), 0);
        Overflow = 1;
        for (int i = 1; i <= 17; i++) begin
            Exec = 1;
            tick();
            check($sformatf("t4 OvfCount %0d", i), int'(OvfCount), (i < 15) ? i : 15);
            Exec = 0;
            tick();
        end
        Overflow = 0; OutReady = 0; Err = 1; Result = 4'h3; Exec = 1;
        tick();
        check("t5 State", int'(State), 2);
        check("t5 ErrSticky", int'(ErrSticky), 1);
        check("t5 FlagsQ", int'(FlagsQ), 8);
        check("t5 OutValid", int'(OutValid), 1);
        check("t5 OvfCount", int'(OvfCount), 15);
        Exec = 0; Err = 0; OutReady = 1;
        tick();
        check("t5 hs OutValid", int'(OutValid), 0);
        check("t5 hs State", int'(State), 2);
        Exec = 1;
        tick();
        check("t5 Drop", int'(Drop), 1);
        check("t5 lock State", int'(State), 2);
        check("t5 lock ResultQ", int'(ResultQ), 3);
        Exec = 0;
        tick();
        check("t5 Drop end", int'(Drop), 0);
        Clear = 1;
        tick();
        all_zero("t5 clear");
        Clear = 0; OutReady = 0;
        tick();
        Clear = 1; Exec = 1; Result = 4'h6;
        tick();
        check("t6 clr State", int'(State), 0);
        check("t6 clr OutValid", int'(OutValid), 0);
        check("t6 clr ResultQ", int'(ResultQ), 0);
        Clear = 0;
        tick();
        check("t6 consumed State", int'(State), 0);
        check("t6 consumed OutValid", int'(OutValid), 0);
        Exec = 0;
        tick();
        Result = 4'hA; Exec = 1;
        tick();
        check("t6 hold State", int'(State), 1);
        check("t6 hold ResultQ", int'(ResultQ), 10);
        #2 rst = 1;
        #1;
        all_zero("t6 async rst");
        tick();
        rst = 0; Exec = 0;
        tick();
        check("t6 after rst State", int'(State), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
